// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and arbiter state encoding shared with decode
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two-port request channel and owner-tagged response channel
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_r;
  logic        rsp_zero;
  logic        busy;
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_ctrl0, req_ctrl1, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_zero, busy
  );
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_ctrl0, req_ctrl1, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_zero, busy
  );
endinterface

// File: rtl/alu.sv
// alu: single-cycle 32-bit integer ALU, unknown op codes yield all ones
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] r,
  output logic        zero
);
  // op decode; unknown codes give all ones so zero drops naturally
  always_comb begin
    r = ctrl == ALU_AND ? a & b :
        ctrl == ALU_OR  ? a | b :
        ctrl == ALU_ADD ? a + b :
        ctrl == ALU_SUB ? a - b :
        ctrl == ALU_XOR ? a ^ b : 32'hFFFF_FFFF;
    zero = r == 32'd0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two ports and holds one owner-tagged result
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  state_t      state;
  logic        prio, g, accept, slot_free, xfer, zero;
  logic [31:0] a, b, r;
  logic [3:0]  ctrl;
  // grant and handshake; rsp_valid is one-hot so the non-owner's rsp_ready is ignored
  always_comb begin
    accept = |(bus.rsp_valid & bus.rsp_ready);
    slot_free = state == IDLE || accept;
    g = &bus.req_valid ? (FAIR ? prio : 1'b0) : bus.req_valid[1];
    bus.req_ready = (!rst && slot_free && |bus.req_valid) ? {g, ~g} : 2'b00;
    xfer = |(bus.req_valid & bus.req_ready);
    a = g ? bus.req_a1 : bus.req_a0;
    b = g ? bus.req_b1 : bus.req_b0;
    ctrl = g ? bus.req_ctrl1 : bus.req_ctrl0;
    bus.busy = state == HOLD;
  end
  alu u_alu (.a(a), .b(b), .ctrl(ctrl), .r(r), .zero(zero));
  // response holding register; a new transfer overwrites an accepted result in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      bus.rsp_valid <= 2'b00;
      bus.rsp_r <= 32'd0;
      bus.rsp_zero <= 1'b0;
    end else if (xfer) begin
      state <= HOLD;
      prio <= FAIR ? ~g : 1'b0;
      bus.rsp_valid <= {g, ~g};
      bus.rsp_r <= r;
      bus.rsp_zero <= zero;
    end else if (accept) begin
      state <= IDLE;
      bus.rsp_valid <= 2'b00;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus fixed-priority sequence for alu_arbiter
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  alu_arbiter_if rr_if ();
  alu_arbiter_if fp_if ();
  alu_arbiter #(.FAIR(1'b1)) dut (.clk(clk), .rst(rst), .bus(rr_if.slave));
  alu_arbiter #(.FAIR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(fp_if.slave));
  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [31:0] a0, b0;
    logic [3:0]  c0;
    logic [31:0] a1, b1;
    logic [3:0]  c1;
    logic [1:0]  rr;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rv;
    logic [31:0] e_r;
    logic        e_z;
    logic        e_busy;
  } vec_t;
  vec_t vecs [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(input vec_t t);
    rst = t.rst;
    rr_if.req_valid = t.v; fp_if.req_valid = t.v;
    rr_if.req_a0 = t.a0; fp_if.req_a0 = t.a0;
    rr_if.req_b0 = t.b0; fp_if.req_b0 = t.b0;
    rr_if.req_ctrl0 = t.c0; fp_if.req_ctrl0 = t.c0;
    rr_if.req_a1 = t.a1; fp_if.req_a1 = t.a1;
    rr_if.req_b1 = t.b1; fp_if.req_b1 = t.b1;
    rr_if.req_ctrl1 = t.c1; fp_if.req_ctrl1 = t.c1;
    rr_if.rsp_ready = t.rr; fp_if.rsp_ready = t.rr;
  endtask
  initial begin
    // rst v a0 b0 c0 a1 b1 c1 rr | rdy rv r z busy
    vecs[0]  = '{0, 2'b01, 5, 7, 4'b0010, 0, 0, 4'b0000, 2'b11, 2'b01, 2'b01, 32'd12, 0, 1};
    vecs[1]  = '{0, 2'b10, 0, 0, 4'b0000, 9, 9, 4'b0110, 2'b11, 2'b10, 2'b10, 32'd0, 1, 1};
    vecs[2]  = '{0, 2'b10, 0, 0, 4'b0000, 3, 4, 4'b1111, 2'b11, 2'b10, 2'b10, 32'hFFFF_FFFF, 0, 1};
    vecs[3]  = '{0, 2'b11, 32'hF0F0, 32'hFF00, 4'b0011, 1, 2, 4'b0001, 2'b11, 2'b01, 2'b01, 32'h0FF0, 0, 1};
    vecs[4]  = '{0, 2'b11, 32'hF0F0, 32'hFF00, 4'b0011, 1, 2, 4'b0001, 2'b11, 2'b10, 2'b10, 32'd3, 0, 1};
    vecs[5]  = '{0, 2'b11, 32'hF0F0, 32'hFF00, 4'b0011, 1, 2, 4'b0001, 2'b11, 2'b01, 2'b01, 32'h0FF0, 0, 1};
    vecs[6]  = '{0, 2'b11, 32'hF0F0, 32'hFF00, 4'b0011, 1, 2, 4'b0001, 2'b11, 2'b10, 2'b10, 32'd3, 0, 1};
    vecs[7]  = '{0, 2'b00, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b11, 2'b00, 2'b00, 32'd3, 0, 0};
    vecs[8]  = '{0, 2'b00, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, 32'd3, 0, 0};
    vecs[9]  = '{0, 2'b01, 32'hFFFF_FFFF, 1, 4'b0010, 0, 0, 4'b0000, 2'b00, 2'b01, 2'b01, 32'd0, 1, 1};
    vecs[10] = '{0, 2'b10, 0, 0, 4'b0000, 32'hFFFF, 32'h0F0F, 4'b0000, 2'b00, 2'b00, 2'b01, 32'd0, 1, 1};
    vecs[11] = '{0, 2'b10, 0, 0, 4'b0000, 32'hFFFF, 32'h0F0F, 4'b0000, 2'b00, 2'b00, 2'b01, 32'd0, 1, 1};
    vecs[12] = '{0, 2'b10, 0, 0, 4'b0000, 32'hFFFF, 32'h0F0F, 4'b0000, 2'b10, 2'b00, 2'b01, 32'd0, 1, 1};
    vecs[13] = '{0, 2'b10, 0, 0, 4'b0000, 32'hFFFF, 32'h0F0F, 4'b0000, 2'b01, 2'b10, 2'b10, 32'h0F0F, 0, 1};
    vecs[14] = '{0, 2'b00, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b01, 2'b00, 2'b10, 32'h0F0F, 0, 1};
    vecs[15] = '{0, 2'b00, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b10, 2'b00, 2'b00, 32'h0F0F, 0, 0};
    vecs[16] = '{0, 2'b01, 5, 7, 4'b0010, 0, 0, 4'b0000, 2'b00, 2'b01, 2'b01, 32'd12, 0, 1};
    vecs[17] = '{1, 2'b11, 32'hF0F0, 32'hFF00, 4'b0011, 1, 2, 4'b0001, 2'b00, 2'b00, 2'b00, 32'd0, 0, 0};
    vecs[18] = '{0, 2'b11, 32'hF0F0, 32'hFF00, 4'b0011, 1, 2, 4'b0001, 2'b11, 2'b01, 2'b01, 32'h0FF0, 0, 1};
    vecs[19] = '{0, 2'b00, 0, 0, 4'b0000, 0, 0, 4'b0000, 2'b11, 2'b00, 2'b00, 32'h0FF0, 0, 0};
    drive('{1, 2'b11, 1, 1, 4'b0010, 1, 1, 4'b0010, 2'b11, 2'b00, 2'b00, 32'd0, 0, 0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset req_ready", {30'd0, rr_if.req_ready}, 32'd0);
    chk("reset rsp_valid", {30'd0, rr_if.rsp_valid}, 32'd0);
    chk("reset rsp_r", rr_if.rsp_r, 32'd0);
    chk("reset rsp_zero", {31'd0, rr_if.rsp_zero}, 32'd0);
    chk("reset busy", {31'd0, rr_if.busy}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d req_ready", i), {30'd0, rr_if.req_ready}, {30'd0, vecs[i].e_rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d rsp_valid", i), {30'd0, rr_if.rsp_valid}, {30'd0, vecs[i].e_rv});
      chk($sformatf("v%0d rsp_r", i), rr_if.rsp_r, vecs[i].e_r);
      chk($sformatf("v%0d rsp_zero", i), {31'd0, rr_if.rsp_zero}, {31'd0, vecs[i].e_z});
      chk($sformatf("v%0d busy", i), {31'd0, rr_if.busy}, {31'd0, vecs[i].e_busy});
    end
    drive('{1, 2'b11, 32'hF0F0, 32'hFF00, 4'b0011, 1, 2, 4'b0001, 2'b11, 2'b00, 2'b00, 32'd0, 0, 0});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("fixed%0d req_ready", i), {30'd0, fp_if.req_ready}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("fixed%0d rsp_valid", i), {30'd0, fp_if.rsp_valid}, 32'd1);
      chk($sformatf("fixed%0d rsp_r", i), fp_if.rsp_r, 32'h0FF0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle 32-bit integer ALU between two requesters, port 0 (execute stage) and port 1 (address/branch helper). Arbitration is round-robin, or fixed priority when configured. The block registers each ALU result together with its owner and presents it on a response channel that supports backpressure. It sits between the decode/issue logic and the `alu` instance, which it owns.

## Interface
- `FAIR`, default 1: 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_valid`  in  2: per-port request valid, bit i = port i.
- `req_ready`  out  2: per-port request accept. A request transfers when `req_valid[i] & req_ready[i]`.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  32 each: operands for port 0 / port 1.
- `req_ctrl0`, `req_ctrl1`  in  4 each: ALU op code for port 0 / port 1.
- `rsp_valid`  out  2: one-hot; the response held belongs to port i.
- `rsp_ready`  in  2: per-port response accept.
- `rsp_r`  out  32: registered ALU result.
- `rsp_zero`  out  1: registered zero flag, 1 iff `rsp_r == 0`.
- `busy`  out  1: a response is held and not yet accepted.

## Operation
- ALU op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0011 XOR
  - any other code gives r = 32'hFFFF_FFFF, zero = 0.
- ADD/SUB are modulo 2^32. No carry or overflow outputs.
- States:
  - IDLE: no response held.
  - HOLD: a response is held.
- `slot_free` = IDLE, or HOLD with the held response accepted this cycle (`rsp_valid[o] & rsp_ready[o]`, o = owner).
- Grant, combinational from `req_valid` and `prio`:
  - Only one port valid: that port.
  - Both ports valid: port `prio` if FAIR=1, port 0 if FAIR=0.
- `req_ready[g] = slot_free` for the granted port g. `req_ready` of the non-granted port is 0.
- On a transfer from port g:
  - Drive the ALU with port g's operands.
  - Register r, zero and owner = g.
  - Next state is HOLD.
  - If FAIR=1, `prio <= ~g`.
- In HOLD, if the response is accepted and no request transfers, next state is IDLE.
- Back-to-back: accept and new transfer in the same cycle means HOLD stays HOLD with the new result. There are no bubble cycles.
- `rsp_r` and `rsp_zero` hold their value while in HOLD. `rsp_ready` of the non-owner port is ignored.
- `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. `rsp_valid`, `rsp_r` and `rsp_zero` are pure register outputs.

## Timing
- Latency: request accepted at edge N gives `rsp_valid` high after edge N, i.e. visible in cycle N+1.
- Throughput: 1 op/cycle when the consumer holds `rsp_ready` high.
- Reset values:
  - state = IDLE
  - `rsp_valid` = 2'b00
  - `rsp_r` = 0
  - `rsp_zero` = 0
  - `busy` = 0
  - `prio` = 0
  - `req_ready` = 0 in the reset cycle; `rst` gates `req_ready` low.
- Reset mid-operation: any held response is dropped with no handshake. Requests presented during reset are not accepted.
- Requester rule: a requester may deassert `req_valid` before it has been accepted. The arbiter must not assume requests are stable.
- Simultaneous requests with FAIR=1 alternate grants strictly: 0,1,0,1 starting from port 0 after reset.
- A single requester is never stalled by an idle other port.
- A stalled response (`rsp_ready` low) blocks both ports. There is no second buffer.

## Structure
- Package `alu_pkg`:
  - localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_XOR` (4-bit).
  - State encoding: IDLE, HOLD.
  - Shared with decode.
- One sub-module: the existing `alu` (ports a, b, ctrl, r, zero), instantiated once. Its inputs are muxed by grant. Its r and zero outputs are registered here.

## Test plan
- Reset, then port 0 ADD a=5, b=7, `rsp_ready`=1 → cycle+1: `rsp_valid`=01, `rsp_r`=12, `rsp_zero`=0.
- Port 1 SUB a=9, b=9 → `rsp_valid`=10, `rsp_r`=0, `rsp_zero`=1. Then ctrl=4'b1111 → `rsp_r`=FFFF_FFFF, `rsp_zero`=0.
- Both ports valid continuously, FAIR=1, port 0 XOR, port 1 OR, `rsp_ready`=11 → owners alternate 0,1,0,1 with one result per cycle. With FAIR=0 → owner always 0 and `req_ready[1]` stays 0.
- Backpressure:
  - Setup: port 0 ADD 0xFFFF_FFFF+1 accepted; `rsp_ready`=00 for 3 cycles.
  - Expect: `rsp_r`=0 and `rsp_zero`=1 stable, `busy`=1, `req_ready`=00 throughout.
  - Raise `rsp_ready[0]` with port 1 valid → same-cycle transfer, next cycle owner = 1.
- Non-owner `rsp_ready[1]`=1 while the port 0 response is held → response not consumed, state stays HOLD.
- Assert `rst` for 1 cycle while in HOLD with both requests valid → next cycle: `rsp_valid`=00, `busy`=0, no transfer during reset, first post-reset grant goes to port 0.
